// File: rtl/prbs_checker_pkg.sv
// PRBS7 definitions shared by the TX prbs generator and the RX prbs_checker.
// Polynomial x^7 + x^6 + 1: the next bit is the XOR of the two oldest taps.
package prbs_package;

    localparam int PRBS_ORDER  = 7;
    localparam int PRBS_TAP_HI = 6;
    localparam int PRBS_TAP_LO = 5;

    typedef logic [PRBS_ORDER-1:0] PRBS_STATE_FORMAT;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } PRBS_CHECK_STATE;

    function automatic logic prbs_predict(input PRBS_STATE_FORMAT sr);
        return sr[PRBS_TAP_HI] ^ sr[PRBS_TAP_LO];
    endfunction

endpackage

// File: rtl/prbs_checker_if.sv
// Bit-stream and result bundle between the RX data path and prbs_checker.
// 'state' exposes the checker FSM for debug and assertion binding.
interface prbs_checker_if #(
    parameter int COUNT_WIDTH = 32
) ();

    // cke is the valid strobe for 'in': a bit is consumed on every clk edge
    // where cke=1. There is no ready; the checker accepts every valid bit.
    logic                          cke;
    logic                          in;
    logic                          clear;
    logic                          locked;
    logic                          err;
    logic [COUNT_WIDTH-1:0]        bit_cnt;
    logic [COUNT_WIDTH-1:0]        err_cnt;
    prbs_package::PRBS_CHECK_STATE state;

    modport master (
        output cke, in, clear,
        input  locked, err, bit_cnt, err_cnt, state
    );

    modport slave (
        input  cke, in, clear,
        output locked, err, bit_cnt, err_cnt, state
    );

endinterface

// File: rtl/prbs_checker_sat_counter.sv
// Saturating up-counter with synchronous clear and asynchronous reset.
// Clear takes priority over a coincident increment.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/prbs_checker.sv
// PRBS7 bit-error-rate checker: self-synchronises in SEARCH, counts bits/errors in LOCKED.
// Define PRBS_CHECKER_AUTOUNLOCK_EN to drop lock when one block collects too many errors.
module prbs_checker
    import prbs_package::*;
#(
    parameter int LOCK_COUNT  = 32,
    parameter int BLOCK_LEN   = 64,
    parameter int UNLOCK_ERRS = 8,
    parameter int COUNT_WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    prbs_checker_if.slave bus
);

    localparam int MATCH_W = $clog2(LOCK_COUNT + 1);

    generate
        if (LOCK_COUNT < 1 || BLOCK_LEN < 2 || (BLOCK_LEN & (BLOCK_LEN - 1)) != 0 ||
            UNLOCK_ERRS < 1 || UNLOCK_ERRS > BLOCK_LEN) begin : g_bad_params
            $error("prbs_checker: illegal LOCK_COUNT/BLOCK_LEN/UNLOCK_ERRS combination");
        end
    endgenerate

    PRBS_CHECK_STATE  state_q, state_d;
    PRBS_STATE_FORMAT sr_q, sr_d;
    logic [2:0]       fill_q, fill_d;
    logic [MATCH_W-1:0] match_q, match_d;
    logic             err_q;
    logic             pred;
    logic             bit_err;
    logic             search_miss;
    logic             cnt_bit;
    logic             cnt_err;

`ifdef PRBS_CHECKER_AUTOUNLOCK_EN
    localparam int POS_W  = $clog2(BLOCK_LEN);
    localparam int BERR_W = $clog2(BLOCK_LEN + 1);

    logic [POS_W-1:0]  blk_pos_q, blk_pos_d;
    logic [BERR_W-1:0] blk_err_q, blk_err_d, blk_err_sum;
`endif

    assign pred = prbs_predict(sr_q);

    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        fill_d      = fill_q;
        match_d     = match_q;
        bit_err     = 1'b0;
        search_miss = 1'b0;
`ifdef PRBS_CHECKER_AUTOUNLOCK_EN
        blk_pos_d   = blk_pos_q;
        blk_err_d   = blk_err_q;
        blk_err_sum = '0;
`endif
        if (bus.cke) begin
            case (state_q)
                SEARCH: begin
                    sr_d = {sr_q[PRBS_ORDER-2:0], bus.in};
                    if (fill_q < 3'(PRBS_ORDER)) begin
                        fill_d = fill_q + 3'd1;
                    end else begin
                        // An all-zero register predicts zeros forever; never lock on it.
                        search_miss = (sr_q == '0) || (bus.in != pred);
                        if (search_miss) begin
                            match_d = '0;
                        end else begin
                            match_d = match_q + MATCH_W'(1);
                            if (match_d == MATCH_W'(LOCK_COUNT)) begin
                                state_d = LOCKED;
                                match_d = '0;
                            end
                        end
                    end
                end
                LOCKED: begin
                    // Free-run on the prediction so one channel error flags exactly one bit.
                    sr_d    = {sr_q[PRBS_ORDER-2:0], pred};
                    bit_err = (bus.in != pred);
`ifdef PRBS_CHECKER_AUTOUNLOCK_EN
                    blk_err_sum = blk_err_q + BERR_W'(bit_err);
                    if (blk_pos_q == POS_W'(BLOCK_LEN - 1)) begin
                        blk_pos_d = '0;
                        blk_err_d = '0;
                        if (blk_err_sum >= BERR_W'(UNLOCK_ERRS)) begin
                            state_d = SEARCH;
                            fill_d  = '0;
                            match_d = '0;
                        end
                    end else begin
                        blk_pos_d = blk_pos_q + POS_W'(1);
                        blk_err_d = blk_err_sum;
                    end
`endif
                end
                default: state_d = SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= SEARCH;
            sr_q      <= '0;
            fill_q    <= '0;
            match_q   <= '0;
`ifdef PRBS_CHECKER_AUTOUNLOCK_EN
            blk_pos_q <= '0;
            blk_err_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            fill_q    <= fill_d;
            match_q   <= match_d;
`ifdef PRBS_CHECKER_AUTOUNLOCK_EN
            blk_pos_q <= blk_pos_d;
            blk_err_q <= blk_err_d;
`endif
        end
    end

    // err holds between strobes; clear wins over a coincident bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (bus.clear) begin
            err_q <= 1'b0;
        end else if (bus.cke) begin
            err_q <= bit_err;
        end
    end

    assign cnt_bit = bus.cke && (state_q == LOCKED);
    assign cnt_err = cnt_bit && bit_err;

    sat_counter #(.WIDTH(COUNT_WIDTH)) u_bit_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (bus.clear),
        .inc   (cnt_bit),
        .count (bus.bit_cnt)
    );

    sat_counter #(.WIDTH(COUNT_WIDTH)) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (bus.clear),
        .inc   (cnt_err),
        .count (bus.err_cnt)
    );

    assign bus.locked = (state_q == LOCKED);
    assign bus.err    = err_q;
    assign bus.state  = state_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Scoreboard bench for prbs_checker: a 32-bit and a 4-bit-counter instance share one stimulus stream.
// Expectations follow the PRBS_CHECKER_AUTOUNLOCK_EN setting of the build.
module tb_prbs_checker;
    import prbs_package::*;

    localparam int EXP_W = 74;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic cke   = 1'b0;
    logic din   = 1'b0;
    logic clear = 1'b0;
    logic tag   = 1'b0;
    logic tag_s = 1'b0;
    logic probe = 1'b0;

    logic [EXP_W-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    logic [6:0] gen = 7'h01;
    int base;

    prbs_checker_if #(.COUNT_WIDTH(32)) bus_a ();
    prbs_checker_if #(.COUNT_WIDTH(4))  bus_s ();

    assign bus_a.cke   = cke;
    assign bus_a.in    = din;
    assign bus_a.clear = clear;
    assign bus_s.cke   = cke;
    assign bus_s.in    = din;
    assign bus_s.clear = clear;

    prbs_checker #(.COUNT_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    prbs_checker #(.COUNT_WIDTH(4)) dut_s (
        .clk (clk),
        .rst (rst),
        .bus (bus_s)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic logic [3:0] sat4(input int v);
        return (v >= 15) ? 4'd15 : 4'(v);
    endfunction

    function automatic logic [EXP_W-1:0] exp_rec(input logic l, input logic e, input int bc,
                                                 input int ec, input logic [3:0] sbc,
                                                 input logic [3:0] sec);
        return {l, e, 32'(bc), 32'(ec), sbc, sec};
    endfunction

    // drivers
    task automatic send_raw(input logic b, input logic clr, input logic tg,
                            input logic [EXP_W-1:0] e);
        din   = b;
        cke   = 1'b1;
        clear = clr;
        tag   = tg;
        if (tg) exp_q.push_back(e);
        @(posedge clk);
        #1;
        cke   = 1'b0;
        clear = 1'b0;
        tag   = 1'b0;
    endtask

    task automatic send(input logic flip, input logic clr, input logic tg,
                        input logic [EXP_W-1:0] e);
        logic b;
        b   = gen[6] ^ gen[5];
        gen = {gen[5:0], b};
        send_raw(b ^ flip, clr, tg, e);
    endtask

    task automatic pulse_probe();
        probe = 1'b1;
        #1;
        probe = 1'b0;
    endtask

    // scoreboard
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
        end
    endtask

    task automatic check_outputs();
        logic [EXP_W-1:0] e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL exp_q_empty: got 0 entries expected 1 at %0t", $time);
            return;
        end
        e = exp_q.pop_front();
        chk("locked",      32'(bus_a.locked),             32'(e[73]));
        chk("state",       32'(bus_a.state == LOCKED),    32'(e[73]));
        chk("err",         32'(bus_a.err),                32'(e[72]));
        chk("bit_cnt",     bus_a.bit_cnt,                 e[71:40]);
        chk("err_cnt",     bus_a.err_cnt,                 e[39:8]);
        chk("sat_bit_cnt", 32'(bus_s.bit_cnt),            32'(e[7:4]));
        chk("sat_err_cnt", 32'(bus_s.err_cnt),            32'(e[3:0]));
    endtask

    always @(posedge clk) tag_s <= tag & cke;

    initial begin
        forever begin
            @(negedge clk or posedge probe);
            if (tag_s || probe) check_outputs();
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    // stimulus
    initial begin
        repeat (2) @(posedge clk);
        #1;
        exp_q.push_back(exp_rec(1'b0, 1'b0, 0, 0, 4'd0, 4'd0));
        pulse_probe();
        rst = 1'b0;

        // all-zero stream must never lock
        for (int i = 1; i <= 500; i++)
            send_raw(1'b0, 1'b0, i == 500, exp_rec(1'b0, 1'b0, 0, 0, 4'd0, 4'd0));

        // clean lock on bit 39, then 1000 clean bits
        do_reset();
        for (int i = 1; i <= 39; i++)
            send(1'b0, 1'b0, i >= 38, exp_rec(i == 39, 1'b0, 0, 0, 4'd0, 4'd0));
        for (int i = 1; i <= 1000; i++)
            send(1'b0, 1'b0, i == 15 || i == 16 || i == 1000,
                 exp_rec(1'b1, 1'b0, i, 0, sat4(i), 4'd0));

        // single errors at bits 100 and 500
        for (int i = 1; i <= 600; i++) begin
            int ec;
            ec = (i >= 500) ? 2 : ((i >= 100) ? 1 : 0);
            send(i == 100 || i == 500, 1'b0, i inside {99, 100, 101, 500, 600},
                 exp_rec(1'b1, i == 100 || i == 500, 1000 + i, ec, 4'd15, sat4(ec)));
        end

        // 8 errors at the start of a fresh 64-bit block
        for (int i = 1; i <= 64; i++) begin
            int ec;
            logic l;
            ec = 2 + ((i < 8) ? i : 8);
`ifdef PRBS_CHECKER_AUTOUNLOCK_EN
            l = (i < 64);
`else
            l = 1'b1;
`endif
            send(i <= 8, 1'b0, i inside {8, 63, 64},
                 exp_rec(l, i <= 8, 1600 + i, ec, 4'd15, sat4(ec)));
        end

        // clean stream resumes: relock after 39 bits, or stay locked
        for (int i = 1; i <= 39; i++) begin
`ifdef PRBS_CHECKER_AUTOUNLOCK_EN
            send(1'b0, 1'b0, i >= 38, exp_rec(i == 39, 1'b0, 1664, 10, 4'd15, 4'd10));
`else
            send(1'b0, 1'b0, i >= 38, exp_rec(1'b1, 1'b0, 1664 + i, 10, 4'd15, 4'd10));
`endif
        end

        // 20 consecutive errors saturate the 4-bit err_cnt
`ifdef PRBS_CHECKER_AUTOUNLOCK_EN
        base = 1664;
`else
        base = 1703;
`endif
        for (int i = 1; i <= 20; i++)
            send(1'b1, 1'b0, i inside {5, 6, 20},
                 exp_rec(1'b1, 1'b1, base + i, 10 + i, 4'd15, sat4(10 + i)));

        // clear coincident with an errored bit: nothing counted
        send(1'b1, 1'b1, 1'b1, exp_rec(1'b1, 1'b0, 0, 0, 4'd0, 4'd0));
        send(1'b0, 1'b0, 1'b1, exp_rec(1'b1, 1'b0, 1, 0, 4'd1, 4'd0));
        send(1'b1, 1'b0, 1'b1, exp_rec(1'b1, 1'b1, 2, 1, 4'd2, 4'd1));

        // asynchronous reset between edges while locked
        send(1'b0, 1'b0, 1'b0, '0);
        send(1'b1, 1'b0, 1'b0, '0);
        #2;
        rst = 1'b1;
        #1;
        exp_q.push_back(exp_rec(1'b0, 1'b0, 0, 0, 4'd0, 4'd0));
        pulse_probe();
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 1; i <= 39; i++)
            send(1'b0, 1'b0, i >= 38, exp_rec(i == 39, 1'b0, 0, 0, 4'd0, 4'd0));
        send(1'b0, 1'b0, 1'b0, '0);
        send(1'b0, 1'b0, 1'b1, exp_rec(1'b1, 1'b0, 2, 0, 4'd2, 4'd0));

        repeat (3) @(posedge clk);
        #1;
        chk("exp_q_left", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/prbs_checker.md
# prbs_checker

Bit-error-rate checker for the recovered RX data stream. It sits directly downstream of the bang-bang phase detector's `data` output (`out_rx`) in the emulated link and consumes one bit per RX-clock enable. It self-synchronises to the PRBS7 pattern generated by the TX `prbs` block and then counts checked bits and bit errors with saturating counters. The counters provide the link's pass/fail and BER figure of merit on the FPGA (ILA/VIO) and in simulation.

## Interface
- `LOCK_COUNT`, 32: consecutive matching bits required in SEARCH before declaring lock (≥1).
- `BLOCK_LEN`, 64: bits per error-monitoring block in LOCKED (≥2, power of two).
- `UNLOCK_ERRS`, 8: errors within one block that force return to SEARCH (1..BLOCK_LEN).
- `COUNT_WIDTH`, 32: width of `bit_cnt` and `err_cnt`.
- `clk` in 1: system clock (`clk_sys`). All state updates only on cycles with `cke`=1.
- `rst` in 1: asynchronous, active-high reset.
- `cke` in 1: bit-valid strobe (`cke_rx_p`).
- `in` in 1: received data bit (`out_rx`).
- `clear` in 1: synchronous counter clear. Honoured regardless of `cke`.
- `locked` out 1: checker is in LOCKED.
- `err` out 1: registered per-bit error flag for the bit just checked.
- `bit_cnt` out COUNT_WIDTH: bits checked while LOCKED, saturating.
- `err_cnt` out COUNT_WIDTH: errors detected while LOCKED, saturating.

## Operation
- Polynomial: x^7+x^6+1. Prediction `pred = sr[6]^sr[5]`, where `sr` is a 7-bit shift register.
- **SEARCH** (reset state), on each `cke`:
  - `sr <= {sr[5:0], in}`.
  - While `fill < 7`, increment `fill`; no comparison is made.
  - Otherwise compare `in` to `pred`. On a match, increment `match`; on a mismatch, set `match <= 0`.
  - If `sr == 0`, always treat the bit as a mismatch. This blocks false lock on an all-zero stream.
  - When a match makes `match == LOCK_COUNT`, go to LOCKED.
  - No counting occurs in SEARCH; `err` = 0.
- **LOCKED**, on each `cke`:
  - The register free-runs on its own prediction: `sr <= {sr[5:0], pred}`. It does not load `in`, so a single channel error produces exactly one `err`.
  - `err <= (in != pred)`.
  - `bit_cnt` increments, saturating at all-ones.
  - `err_cnt` increments by `err`, saturating at all-ones.
  - `blk_pos` counts 0..BLOCK_LEN-1 and wraps. `blk_err` accumulates errors within the block, including the current bit.
  - On the last bit of a block: if `blk_err ≥ UNLOCK_ERRS`, go to SEARCH with `fill=0`, `match=0`. Clear `blk_err` and `blk_pos` in either case.
- Counters hold their values across unlock/relock; only `clear` or `rst` zeroes them.
- `clear` zeroes `bit_cnt`, `err_cnt` and `err`. It does not change the state, `sr`, or the block counters.
- `clear` with `cke` in the same cycle: `clear` wins and the bit is not counted. The prediction still advances.
- Saturation: when a counter is at all-ones, further increments hold it there and do not wrap.

## Timing
- Reset values: `locked`=0, `err`=0, `bit_cnt`=0, `err_cnt`=0, state SEARCH, `sr`=0, `fill`=0, `match`=0, `blk_pos`=0, `blk_err`=0.
- All outputs are registered. `err`, `bit_cnt` and `err_cnt` reflect bit N on the `clk` edge that samples bit N (one-edge latency).
- `err` holds its value between `cke` strobes.
- Lock timing: at the earliest, `locked` rises on the edge sampling bit 7+LOCK_COUNT, counting from the first bit after reset.
- Unlock timing: `locked` falls on the edge sampling the last bit of the offending block. That bit is still counted.
- `rst` mid-operation clears everything asynchronously. Operation resumes on the first `cke` after deassertion.

## Configuration
- `PRBS_CHECKER_AUTOUNLOCK_EN`:
  - Defined: block-based unlock as above.
  - Undefined: `blk_pos`/`blk_err` are not built, and LOCKED is left only by `rst`. Use this for error-burst capture where relock would hide a slip.

## Structure
- Create a new `prbs_package` holding:
  - `PRBS_ORDER`=7 and the tap constants shared with the TX `prbs` block.
  - `PRBS_STATE_FORMAT` typedef.
  - Checker state enum `PRBS_CHECK_STATE {SEARCH, LOCKED}`.
- Sub-module `sat_counter` (width parameter; inputs `inc`, `clear`; async `rst`), instantiated for `bit_cnt` and `err_cnt`.

## Test plan
- Clean PRBS7 stream with `cke` every cycle → `locked`=1 on bit 39 (LOCK_COUNT=32). After 1000 further bits: `bit_cnt`=1000, `err_cnt`=0.
- Locked stream with bits 100 and 500 inverted → exactly two single-cycle `err` pulses, `err_cnt`=2, `locked` stays 1.
- All-zero input for 500 bits → `locked` stays 0, counters 0.
- Locked, then 8 errors injected in one 64-bit block → `locked` falls at block end and relocks 39 bits after a clean stream resumes; counters retained. With macro undefined → stays locked, `err_cnt`=8.
- `COUNT_WIDTH`=4, clean lock, then 20 bits with 20 errors → both counters hold at 15. `clear` coincident with `cke` → both 0, that bit not counted.
- `rst` asserted mid-LOCKED, asynchronously between edges → all outputs 0 immediately; relock after 39 bits.
